// File: rtl/emu_step_transactor.sv
// Byte-wide host transactor for one emulated DUT: shadow/stimulus bytes, capture bytes,
// and a run controller that clock-enables the DUT for a host-chosen number of cycles.
module emu_step_transactor #(
    parameter int STIM_BYTES = 3,
    parameter int OUT_BYTES  = 2,
    parameter int ADDR_W     = 3,
    parameter int AUTO_GET   = 1
) (
    input  logic                    clk_emu,
    input  logic                    rst_emu_n,
    input  logic [7:0]              Din_emu,
    input  logic [ADDR_W-1:0]       Addr_emu,
    input  logic                    wr_emu,
    input  logic                    load_emu,
    input  logic                    get_emu,
    input  logic                    run_emu,
    output logic [7:0]              Dout_emu,
    output logic                    busy_emu,
    output logic                    done_emu,
    output logic [8*STIM_BYTES-1:0] stim_bus,
    input  logic [8*OUT_BYTES-1:0]  out_bus,
    output logic                    dut_ce
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [8*STIM_BYTES-1:0] shadow_q, shadow_d;
    logic [8*STIM_BYTES-1:0] stim_q, stim_d;
    logic [8*OUT_BYTES-1:0]  cap_q, cap_d;
    logic [7:0]              dout_q, dout_d;

    logic busy;
    logic doLoad, doGet, doRun, doWr;

    // Only the highest-priority asserted command acts, even if it is then ignored.
    assign busy   = (state_q == ST_RUN);
    assign doLoad = load_emu;
    assign doGet  = !load_emu && get_emu;
    assign doRun  = !load_emu && !get_emu && run_emu;
    assign doWr   = !load_emu && !get_emu && !run_emu && wr_emu;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        stim_d   = stim_q;
        cap_d    = cap_q;
        dout_d   = dout_q;

        case (state_q)
            ST_RUN: begin
                cnt_d = cnt_q - 9'd1;
                if (cnt_q == 9'd1) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                if (AUTO_GET != 0) begin
                    cap_d = out_bus;
                end
            end
            default: ;
        endcase

        if (doLoad && !busy) begin
            stim_d = shadow_q;
        end

        // A host get during FINISH captures the same value as the auto-capture.
        if (doGet) begin
            cap_d = out_bus;
        end

        // FINISH counts as idle, so back-to-back runs lose only that one cycle.
        if (doRun && !busy) begin
            state_d = ST_RUN;
            cnt_d   = (Din_emu == 8'd0) ? 9'd256 : {1'b0, Din_emu};
        end

        if (doWr) begin
            for (int k = 0; k < STIM_BYTES; k++) begin
                if (Addr_emu == k[ADDR_W-1:0]) begin
                    shadow_d[8*k +: 8] = Din_emu;
                end
            end
        end

        if (!load_emu && !get_emu) begin
            dout_d = 8'h00;
            for (int k = 0; k < OUT_BYTES; k++) begin
                if (Addr_emu == k[ADDR_W-1:0]) begin
                    dout_d = cap_q[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_emu) begin
        if (!rst_emu_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            stim_q   <= '0;
            cap_q    <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            stim_q   <= stim_d;
            cap_q    <= cap_d;
            dout_q   <= dout_d;
        end
    end

    assign Dout_emu = dout_q;
    assign busy_emu = busy;
    assign dut_ce   = busy;
    assign done_emu = (state_q == ST_FINISH);
    assign stim_bus = stim_q;

endmodule
